// File: rtl/ps2_key_event_ctrl_pkg.sv
// Shared types and constants for the PS/2 key event controller.
package ps2_pkg;

  // Prefix state machine: which prefixes are pending for the next code byte.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_e;

  // Scan-code prefixes.
  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;

  // Keyboard replies to host commands; these never form key events.
  localparam logic [7:0] PS2_BAT    = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;

  // One queued key event.
  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;

  // True for bytes the keyboard sends as command responses.
  function automatic logic is_device_response(input logic [7:0] b);
    return (b == PS2_BAT) || (b == PS2_ACK) || (b == PS2_RESEND) || (b == PS2_ECHO);
  endfunction

endpackage

// File: rtl/ps2_key_event_ctrl_if.sv
// Signal bundle between the PS/2 receiver/consumer side and the controller.
// Handshake: an event transfers on every clock edge where evt_valid and
// evt_ready are both high; evt_valid never depends on evt_ready, and the
// head event data holds steady while evt_valid=1 and evt_ready=0.
interface ps2_key_event_ctrl_if;
  import ps2_pkg::*;

  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_err;
  logic       frame_active;
  logic       rx_flush;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;
  logic       overflow;
  logic       clr_ovf;
  logic [7:0] err_count;
  ps2_state_e fsm_state;   // debug view of the prefix FSM

  // Controller side.
  modport slave (
    input  byte_data, byte_valid, byte_err, frame_active, evt_ready, clr_ovf,
    output rx_flush, evt_valid, evt_code, evt_ext, evt_break, overflow,
           err_count, fsm_state
  );

  // Receiver/consumer side.
  modport master (
    output byte_data, byte_valid, byte_err, frame_active, evt_ready, clr_ovf,
    input  rx_flush, evt_valid, evt_code, evt_ext, evt_break, overflow,
           err_count, fsm_state
  );

endinterface

// File: rtl/ps2_key_event_ctrl_fifo.sv
// Show-ahead synchronous FIFO with count-based full/empty flags.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module ps2_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] pop_data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok;
  logic          pop_ok;

  assign full_o     = (count_q == (AW+1)'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign pop_ok     = pop_i && !empty_o;
  assign push_ok    = push_i && (!full_o || pop_ok);
  assign pop_data_o = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; pointers wrap since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are only meaningful behind the count.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/ps2_key_event_ctrl.sv
// PS/2 key event controller: prefix decoding, event queue and receiver
// supervision (watchdog, error counting, flush).
module ps2_key_event_ctrl #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ps2_key_event_ctrl_if.slave  bus
);
  import ps2_pkg::*;

  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  ps2_state_e      state_q, state_d;
  logic            emit;
  ps2_evt_t        emit_evt;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            wd_timeout;
  logic            err_event;
  logic            byte_ok;
  logic            is_resp;
  logic            is_prefix;
  logic [7:0]      err_q, err_d;
  logic            flush_q, flush_d;
  logic            ovf_q, ovf_d;
  logic            fifo_full;
  logic            fifo_empty;
  logic            pop;
  ps2_evt_t        head;

  // A timeout or receiver error in a cycle discards any byte arriving with it.
  assign wd_timeout = bus.frame_active && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
  assign err_event  = wd_timeout || bus.byte_err;
  assign byte_ok    = bus.byte_valid && !err_event;
  assign is_resp    = is_device_response(bus.byte_data);
  assign is_prefix  = (bus.byte_data == PS2_EXT) || (bus.byte_data == PS2_BRK);

  // Prefix FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Prefix FSM next state: errors and device responses resynchronise to IDLE.
  always_comb begin
    state_d = state_q;
    if (err_event) begin
      state_d = ST_IDLE;
    end else if (byte_ok) begin
      if (is_resp) begin
        state_d = ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (bus.byte_data == PS2_EXT)      state_d = ST_EXT;
            else if (bus.byte_data == PS2_BRK) state_d = ST_BRK;
            else                               state_d = ST_IDLE;
          end
          ST_EXT: begin
            if (bus.byte_data == PS2_BRK)      state_d = ST_EXT_BRK;
            else if (bus.byte_data == PS2_EXT) state_d = ST_EXT;
            else                               state_d = ST_IDLE;
          end
          ST_BRK: begin
            if (bus.byte_data == PS2_BRK)      state_d = ST_BRK;
            else if (bus.byte_data == PS2_EXT) state_d = ST_EXT_BRK;
            else                               state_d = ST_IDLE;
          end
          ST_EXT_BRK: begin
            if (is_prefix) state_d = ST_EXT_BRK;
            else           state_d = ST_IDLE;
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  // Prefix FSM outputs: a non-prefix, non-response byte emits an event
  // tagged with the prefixes collected so far.
  always_comb begin
    emit          = byte_ok && !is_resp && !is_prefix;
    emit_evt.ext  = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
    emit_evt.brk  = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
    emit_evt.code = bus.byte_data;
  end

  // Watchdog next count: runs only while a frame is in progress.
  always_comb begin
    wd_d = '0;
    if (bus.frame_active && !wd_timeout) wd_d = wd_q + WD_W'(1);
  end

  // Supervision next state: error counter, flush pulse and sticky overflow.
  always_comb begin
    err_d   = err_q;
    flush_d = err_event;
    ovf_d   = ovf_q;
    if (err_event && (err_q != 8'hFF)) err_d = err_q + 8'd1;
    if (bus.clr_ovf)                   ovf_d = 1'b0;
    if (emit && fifo_full && !pop)     ovf_d = 1'b1;
  end

  // Supervision registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q    <= '0;
      err_q   <= '0;
      flush_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wd_q    <= wd_d;
      err_q   <= err_d;
      flush_q <= flush_d;
      ovf_q   <= ovf_d;
    end
  end

  assign pop = !fifo_empty && bus.evt_ready;

  ps2_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(ps2_evt_t))
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (emit),
    .push_data_i (emit_evt),
    .pop_i       (pop),
    .pop_data_o  (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Head event fields are forced to zero while the queue is empty.
  assign bus.evt_valid = !fifo_empty;
  assign bus.evt_code  = fifo_empty ? 8'h00 : head.code;
  assign bus.evt_ext   = !fifo_empty && head.ext;
  assign bus.evt_break = !fifo_empty && head.brk;
  assign bus.rx_flush  = flush_q;
  assign bus.overflow  = ovf_q;
  assign bus.err_count = err_q;
  assign bus.fsm_state = state_q;

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Directed bench for ps2_key_event_ctrl (FIFO_DEPTH=4, TIMEOUT_CYCLES=16).
module tb_ps2_key_event_ctrl;
  import ps2_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  ps2_key_event_ctrl_if bus();

  ps2_key_event_ctrl #(
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] b;
    logic       exp_v;
    logic       exp_ext;
    logic       exp_brk;
    logic [7:0] exp_code;
    ps2_state_e exp_st;
  } vec_t;

  vec_t vecs [20];

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.byte_data    = 8'h00;
    bus.byte_valid   = 1'b0;
    bus.byte_err     = 1'b0;
    bus.frame_active = 1'b0;
    bus.evt_ready    = 1'b0;
    bus.clr_ovf      = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Driver: one byte_valid cycle, leaves the bench 1 time unit after the edge.
  task automatic send_byte(input logic [7:0] b);
    bus.byte_data  = b;
    bus.byte_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_head(input string name, input logic v, input logic e,
                            input logic k, input logic [7:0] c);
    check({name, "_valid"}, 32'(bus.evt_valid), 32'(v));
    check({name, "_ext"},   32'(bus.evt_ext),   32'(e));
    check({name, "_brk"},   32'(bus.evt_break), 32'(k));
    check({name, "_code"},  32'(bus.evt_code),  32'(c));
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    vecs[0]  = '{8'h1C, 1'b1, 1'b0, 1'b0, 8'h1C, ST_IDLE};
    vecs[1]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 8'h00, ST_BRK};
    vecs[2]  = '{8'h1C, 1'b1, 1'b0, 1'b1, 8'h1C, ST_IDLE};
    vecs[3]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 8'h00, ST_EXT};
    vecs[4]  = '{8'h75, 1'b1, 1'b1, 1'b0, 8'h75, ST_IDLE};
    vecs[5]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 8'h00, ST_EXT};
    vecs[6]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 8'h00, ST_EXT_BRK};
    vecs[7]  = '{8'h75, 1'b1, 1'b1, 1'b1, 8'h75, ST_IDLE};
    vecs[8]  = '{8'hAA, 1'b0, 1'b0, 1'b0, 8'h00, ST_IDLE};
    vecs[9]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 8'h00, ST_EXT};
    vecs[10] = '{8'hFA, 1'b0, 1'b0, 1'b0, 8'h00, ST_IDLE};
    vecs[11] = '{8'h1C, 1'b1, 1'b0, 1'b0, 8'h1C, ST_IDLE};
    vecs[12] = '{8'hF0, 1'b0, 1'b0, 1'b0, 8'h00, ST_BRK};
    vecs[13] = '{8'hF0, 1'b0, 1'b0, 1'b0, 8'h00, ST_BRK};
    vecs[14] = '{8'hE0, 1'b0, 1'b0, 1'b0, 8'h00, ST_EXT_BRK};
    vecs[15] = '{8'hE0, 1'b0, 1'b0, 1'b0, 8'h00, ST_EXT_BRK};
    vecs[16] = '{8'h5A, 1'b1, 1'b1, 1'b1, 8'h5A, ST_IDLE};
    vecs[17] = '{8'hE0, 1'b0, 1'b0, 1'b0, 8'h00, ST_EXT};
    vecs[18] = '{8'hE0, 1'b0, 1'b0, 1'b0, 8'h00, ST_EXT};
    vecs[19] = '{8'h6B, 1'b1, 1'b1, 1'b0, 8'h6B, ST_IDLE};

    // Reset state
    do_reset();
    check_head("rst", 1'b0, 1'b0, 1'b0, 8'h00);
    check("rst_flush", 32'(bus.rx_flush),  32'd0);
    check("rst_ovf",   32'(bus.overflow),  32'd0);
    check("rst_err",   32'(bus.err_count), 32'd0);
    check("rst_state", 32'(bus.fsm_state), 32'(ST_IDLE));

    // Table-driven prefix decoding; consumer always ready, so each event
    // is visible the cycle after its final byte and gone one cycle later.
    bus.evt_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      send_byte(vecs[i].b);
      check_head($sformatf("vec%0d", i), vecs[i].exp_v, vecs[i].exp_ext,
                 vecs[i].exp_brk, vecs[i].exp_code);
      check($sformatf("vec%0d_state", i), 32'(bus.fsm_state), 32'(vecs[i].exp_st));
    end
    step();
    check("table_drained", 32'(bus.evt_valid), 32'd0);
    check("table_err", 32'(bus.err_count), 32'd0);

    // Overflow: six make codes into a depth-4 queue with no consumer.
    do_reset();
    for (int i = 0; i < 6; i++) send_byte(8'(8'h10 + i));
    check("ovf_set", 32'(bus.overflow), 32'd1);
    check_head("ovf_head", 1'b1, 1'b0, 1'b0, 8'h10);
    step();
    check_head("ovf_hold", 1'b1, 1'b0, 1'b0, 8'h10);
    bus.evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_head($sformatf("drain%0d", i), 1'b1, 1'b0, 1'b0, 8'(8'h10 + i));
      step();
    end
    check_head("drain_empty", 1'b0, 1'b0, 1'b0, 8'h00);
    check("ovf_sticky", 32'(bus.overflow), 32'd1);
    bus.evt_ready = 1'b0;
    bus.clr_ovf   = 1'b1;
    step();
    bus.clr_ovf   = 1'b0;
    check("ovf_clr", 32'(bus.overflow), 32'd0);

    // Full queue with simultaneous pop accepts the push.
    for (int i = 0; i < 4; i++) send_byte(8'(8'h30 + i));
    bus.evt_ready = 1'b1;
    send_byte(8'h34);
    check("fullpop_ovf", 32'(bus.overflow), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check_head($sformatf("fullpop%0d", i), 1'b1, 1'b0, 1'b0, 8'(8'h31 + i));
      step();
    end
    check("fullpop_empty", 32'(bus.evt_valid), 32'd0);

    // Error discards a pending break prefix.
    do_reset();
    bus.evt_ready = 1'b1;
    send_byte(8'hF0);
    bus.byte_err = 1'b1;
    step();
    bus.byte_err = 1'b0;
    check("err_flush", 32'(bus.rx_flush),  32'd1);
    check("err_cnt",   32'(bus.err_count), 32'd1);
    check("err_state", 32'(bus.fsm_state), 32'(ST_IDLE));
    step();
    check("err_flush_end", 32'(bus.rx_flush), 32'd0);
    send_byte(8'h1C);
    check_head("err_evt", 1'b1, 1'b0, 1'b0, 8'h1C);
    check("err_cnt_hold", 32'(bus.err_count), 32'd1);

    // Watchdog: frame_active for 16 cycles, flush seen in cycle 17.
    do_reset();
    bus.frame_active = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      step();
      check($sformatf("wd_quiet%0d", k), 32'(bus.rx_flush), 32'd0);
    end
    step();
    check("wd_flush", 32'(bus.rx_flush),  32'd1);
    check("wd_err",   32'(bus.err_count), 32'd1);
    step();
    check("wd_flush_end", 32'(bus.rx_flush), 32'd0);
    bus.frame_active = 1'b0;
    step();
    check("wd_err_hold", 32'(bus.err_count), 32'd1);

    // Timeout coinciding with byte_err and a byte: one error, byte dropped.
    do_reset();
    bus.evt_ready    = 1'b1;
    bus.frame_active = 1'b1;
    repeat (15) step();
    bus.byte_err   = 1'b1;
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h1C;
    step();
    bus.byte_err     = 1'b0;
    bus.byte_valid   = 1'b0;
    bus.frame_active = 1'b0;
    check("both_err",   32'(bus.err_count), 32'd1);
    check("both_flush", 32'(bus.rx_flush),  32'd1);
    check("both_noevt", 32'(bus.evt_valid), 32'd0);
    step();
    check("both_flush_end", 32'(bus.rx_flush),  32'd0);
    check("both_err_hold",  32'(bus.err_count), 32'd1);

    // Error counter saturation.
    do_reset();
    bus.byte_err = 1'b1;
    repeat (300) step();
    bus.byte_err = 1'b0;
    check("sat_err", 32'(bus.err_count), 32'hFF);

    // Asynchronous reset with events queued and an EXT_BRK prefix pending.
    do_reset();
    bus.byte_err = 1'b1;
    step();
    bus.byte_err = 1'b0;
    send_byte(8'h1C);
    send_byte(8'h1D);
    send_byte(8'h1E);
    send_byte(8'hE0);
    send_byte(8'hF0);
    check("pre_rst_state", 32'(bus.fsm_state), 32'(ST_EXT_BRK));
    check("pre_rst_err",   32'(bus.err_count), 32'd1);
    check_head("pre_rst", 1'b1, 1'b0, 1'b0, 8'h1C);
    #2 rst_n = 1'b0;
    #1;
    check_head("async_rst", 1'b0, 1'b0, 1'b0, 8'h00);
    check("async_rst_err",   32'(bus.err_count), 32'd0);
    check("async_rst_flush", 32'(bus.rx_flush),  32'd0);
    check("async_rst_ovf",   32'(bus.overflow),  32'd0);
    check("async_rst_state", 32'(bus.fsm_state), 32'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    step();
    bus.evt_ready = 1'b1;
    send_byte(8'h1C);
    check_head("post_rst", 1'b1, 1'b0, 1'b0, 8'h1C);
    step();
    check("post_rst_empty", 32'(bus.evt_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
